// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: blank code and hex glyph table.
// Codes are active-low {DP,g,f,e,d,c,b,a} with the decimal point off.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [7:0] SEG_HEX [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hD8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment code (DP excluded).
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_HEX[nibble][6:0];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with a double-buffered
// display value, per-digit DP/enable and leading-zero suppression.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg,
    output logic                    frame_tick
);

    localparam int PRESC_W = $clog2(REFRESH_DIV);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PRESC_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [4*NUM_DIGITS-1:0] active_val_q, active_val_d;
    logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
    logic                    pending_q, pending_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [7:0]              seg_q, seg_d;

    logic                    tc;
    logic                    wrap;
    logic [NUM_DIGITS-1:0]   zero_from;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_en;
    logic                    cur_zero;
    logic [6:0]              hex_seg;

    assign tc         = (presc_q == PRESC_W'(REFRESH_DIV - 1));
    assign wrap       = tc && (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign frame_tick = wrap;
    assign an         = an_q;
    assign seg        = seg_q;

    always_comb begin
        presc_d = tc ? '0 : presc_q + PRESC_W'(1);
        idx_d   = idx_q;
        if (tc) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // A load landing on the wrap edge bypasses the shadow so it shows this frame.
    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        active_val_d = active_val_q;
        active_dp_d  = active_dp_q;
        pending_d    = pending_q;
        if (load) begin
            shadow_val_d = value_in;
            shadow_dp_d  = dp_in;
            if (wrap) begin
                active_val_d = value_in;
                active_dp_d  = dp_in;
                pending_d    = 1'b0;
            end else begin
                pending_d = 1'b1;
            end
        end else if (wrap && pending_q) begin
            active_val_d = shadow_val_q;
            active_dp_d  = shadow_dp_q;
            pending_d    = 1'b0;
        end
    end

    // zero_from[i] is set when nibble i and every nibble to its left are zero.
    always_comb begin
        zero_from = '0;
        zero_from[NUM_DIGITS-1] = (active_val_q[4*NUM_DIGITS-1 -: 4] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (active_val_q[4*i +: 4] == 4'h0);
        end
    end

    always_comb begin
        cur_nib  = '0;
        cur_dp   = 1'b0;
        cur_en   = 1'b0;
        cur_zero = 1'b0;
        an_d     = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib  = active_val_q[4*i +: 4];
                cur_dp   = active_dp_q[i];
                cur_en   = digit_en[i];
                cur_zero = zero_from[i];
                an_d[i]  = 1'b0;
            end
        end
    end

    seg7_hex_decode u_hex_decode (
        .nibble (cur_nib),
        .seg_n  (hex_seg)
    );

    always_comb begin
        seg_d = {~cur_dp, hex_seg};
        if (!cur_en) begin
            seg_d = SEG_BLANK;
        end else if (lz_en && (idx_q != '0) && cur_zero) begin
            seg_d = {~cur_dp, 7'h7F};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            active_val_q <= '0;
            active_dp_q  <= '0;
            pending_q    <= 1'b0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            active_val_q <= active_val_d;
            active_dp_q  <= active_dp_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

endmodule
